// File: rtl/mode_select_pkg.sv
// Shared types and helpers for the front-panel mode controller.
// Mode arithmetic wraps at the mode count, not at a power of two.
package mode_select_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    SELECT = 1'b1
  } state_t;

  localparam int DEFAULT_NEXT_IDX    = 4;
  localparam int DEFAULT_CONFIRM_IDX = 3;
  localparam int DEFAULT_CANCEL_IDX  = 2;

  function automatic int unsigned next_mode(input int unsigned cur, input int unsigned n);
    return (cur >= n - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Single-button two-flop synchroniser followed by a stable-count debouncer.
// Produces the debounced level and a registered one-cycle press pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips on the cycle the counter would reach DEBOUNCE_CYCLES; pulse rises with it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/mode_select_ctrl.sv
// Front-panel mode controller: debounced buttons feed a browse/confirm/cancel FSM
// that owns the committed mode, the displayed candidate and the selection timeout.
module mode_select_ctrl
  import mode_select_pkg::*;
#(
  parameter int NUM_BUTTONS     = 5,
  parameter int NUM_MODES       = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SELECT_TIMEOUT  = 50000000,
  parameter int NEXT_IDX        = DEFAULT_NEXT_IDX,
  parameter int CONFIRM_IDX     = DEFAULT_CONFIRM_IDX,
  parameter int CANCEL_IDX      = DEFAULT_CANCEL_IDX
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_BUTTONS-1:0]       buttons,
  output logic [NUM_BUTTONS-1:0]       btn_level,
  output logic [NUM_BUTTONS-1:0]       btn_pulse,
  output logic [$clog2(NUM_MODES)-1:0] mode,
  output logic [$clog2(NUM_MODES)-1:0] cand_mode,
  output logic                         selecting,
  output logic                         mode_changed
);

  localparam int MW = $clog2(NUM_MODES);
  localparam int TW = $clog2(SELECT_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SELECT_TIMEOUT - 1);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (buttons[i]),
      .level(btn_level[i]),
      .pulse(btn_pulse[i])
    );
  end

  logic next_p, confirm_p, cancel_p;
  assign next_p    = btn_pulse[NEXT_IDX];
  assign confirm_p = btn_pulse[CONFIRM_IDX];
  assign cancel_p  = btn_pulse[CANCEL_IDX];

  state_t          state_q, state_d;
  logic [MW-1:0]   mode_q, mode_d;
  logic [MW-1:0]   cand_q, cand_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            changed_q, changed_d;

  // Timer stays at zero outside SELECT and on every consumed pulse; expiry behaves as cancel.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cand_d    = cand_q;
    timer_d   = '0;
    changed_d = 1'b0;
    case (state_q)
      RUN: begin
        if (next_p) begin
          state_d = SELECT;
          cand_d  = MW'(next_mode(32'(mode_q), NUM_MODES));
        end
      end
      SELECT: begin
        if (cancel_p) begin
          state_d = RUN;
          cand_d  = mode_q;
        end else if (confirm_p) begin
          state_d   = RUN;
          mode_d    = cand_q;
          changed_d = (cand_q != mode_q);
        end else if (next_p) begin
          cand_d = MW'(next_mode(32'(cand_q), NUM_MODES));
        end else if (timer_q == TIMER_LAST) begin
          state_d = RUN;
          cand_d  = mode_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      mode_q    <= '0;
      cand_q    <= '0;
      timer_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cand_q    <= cand_d;
      timer_q   <= timer_d;
      changed_q <= changed_d;
    end
  end

  assign mode         = mode_q;
  assign cand_mode    = cand_q;
  assign selecting    = (state_q == SELECT);
  assign mode_changed = changed_q;

endmodule
